instr_cache: RTL

Direct-mapped, read-only instruction cache placed between the `cpu` fetch port (PC out, INSTRUCTION in) and the slow instruction memory. It answers instruction fetches in the same cycle on a hit. On a miss it stalls the CPU with BUSYWAIT, fetches a 4-word block from memory through a BUSYWAIT handshake, fills the line, then serves the fetch. It is the responder for the CPU's fetch interface and the initiator toward instruction memory.

---
 rtl/icache_pkg.sv | 27 ++
 rtl/icache_fsm.sv | 82 ++++++++
 rtl/instr_cache.sv | 100 ++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// ---------------------------------------------------------------------------
// icache_pkg
// Shared sizing constants, derived field widths and the controller state
// type for the direct-mapped, read-only instruction cache.
// ---------------------------------------------------------------------------
package icache_pkg;

  localparam int ADDR_BITS       = 10;
  localparam int NUM_BLOCKS      = 8;
  localparam int WORDS_PER_BLOCK = 4;

  localparam int OFFSET_W  = $clog2(WORDS_PER_BLOCK);
  localparam int INDEX_W   = $clog2(NUM_BLOCKS);
  localparam int TAG_W     = ADDR_BITS - INDEX_W - OFFSET_W - 2;
  localparam int BLOCK_W   = 32 * WORDS_PER_BLOCK;
  // Block address = {tag, index}; this is what memory sees.
  localparam int BLKADDR_W = TAG_W + INDEX_W;

  typedef logic [WORDS_PER_BLOCK-1:0][31:0] block_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEM_FETCH = 2'd1,
    UPDATE    = 2'd2
  } cacheState_e;

endpackage

// File: rtl/icache_fsm.sv
// ---------------------------------------------------------------------------
// icache_fsm
// Miss controller: holds the state register and the latched block address.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   hit_i                combinational hit for the current fetch address
//   blockAddr_i          {tag,index} of the current fetch address
//   memBusywait_i        instruction memory busy
//   memRead_o            block read request to memory
//   memAddress_o         latched block address (also selects the fill line)
//   busywait_o           stall request to the CPU
//   capture_o            load the fill register this edge
//   lineWrite_o          write fill register into the latched line this edge
// ---------------------------------------------------------------------------
module icache_fsm
  import icache_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 hit_i,
  input  logic [BLKADDR_W-1:0] blockAddr_i,
  input  logic                 memBusywait_i,
  output logic                 memRead_o,
  output logic [BLKADDR_W-1:0] memAddress_o,
  output logic                 busywait_o,
  output logic                 capture_o,
  output logic                 lineWrite_o
);

  cacheState_e          state_q, state_d;
  logic [BLKADDR_W-1:0] blockAddr_q, blockAddr_d;
  logic                 busyRaw;

  // State and latched block address; reset aborts any fill in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      blockAddr_q <= '0;
    end else begin
      state_q     <= state_d;
      blockAddr_q <= blockAddr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    blockAddr_d = blockAddr_q;
    memRead_o   = 1'b0;
    busyRaw     = 1'b0;
    capture_o   = 1'b0;
    lineWrite_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hit_i) begin
          busyRaw     = 1'b1;
          state_d     = MEM_FETCH;
          blockAddr_d = blockAddr_i;
        end
      end
      MEM_FETCH: begin
        memRead_o = 1'b1;
        busyRaw   = 1'b1;
        if (!memBusywait_i) begin
          capture_o = 1'b1;
          state_d   = UPDATE;
        end
      end
      UPDATE: begin
        busyRaw     = 1'b1;
        lineWrite_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Held in reset every line is invalid, so the raw miss would stall the
  // CPU; the stall is suppressed until reset is released.
  assign busywait_o   = busyRaw & rst_ni;
  assign memAddress_o = blockAddr_q;

endmodule

// File: rtl/instr_cache.sv
// ---------------------------------------------------------------------------
// instr_cache
// Direct-mapped read-only instruction cache, 8 lines x 4 words.
// Ports:
//   CLK, RESET       clock, asynchronous active-low reset
//   ADDRESS          fetch byte address (bits [9:2] used)
//   INSTRUCTION      fetched word, 0 while not valid
//   BUSYWAIT         stall request to the CPU
//   MEM_READ         block read request to instruction memory
//   MEM_ADDRESS      block address toward memory
//   MEM_READDATA     128-bit block from memory
//   MEM_BUSYWAIT     memory busy; data valid in the cycle it falls
// ---------------------------------------------------------------------------
module instr_cache
  import icache_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          ADDRESS,
  output logic [31:0]          INSTRUCTION,
  output logic                 BUSYWAIT,
  output logic                 MEM_READ,
  output logic [BLKADDR_W-1:0] MEM_ADDRESS,
  input  logic [BLOCK_W-1:0]   MEM_READDATA,
  input  logic                 MEM_BUSYWAIT
);

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  block_t                data_q [NUM_BLOCKS];
  block_t                fill_q;

  logic [OFFSET_W-1:0]  offset;
  logic [INDEX_W-1:0]   index;
  logic [TAG_W-1:0]     tag;
  logic [BLKADDR_W-1:0] blockAddr;
  logic [INDEX_W-1:0]   wrIndex;
  logic [TAG_W-1:0]     wrTag;
  logic                 hit;
  logic                 capture;
  logic                 lineWrite;
  logic                 unusedAddrBits;

  assign offset    = ADDRESS[2 +: OFFSET_W];
  assign index     = ADDRESS[2 + OFFSET_W +: INDEX_W];
  assign tag       = ADDRESS[2 + OFFSET_W + INDEX_W +: TAG_W];
  assign blockAddr = ADDRESS[ADDR_BITS-1:2 + OFFSET_W];
  assign unusedAddrBits = ^{ADDRESS[31:ADDR_BITS], ADDRESS[1:0]};

  // The line being filled is named by the latched block address, not the
  // live ADDRESS, so a PC change mid-fill cannot corrupt another line.
  assign wrIndex = MEM_ADDRESS[INDEX_W-1:0];
  assign wrTag   = MEM_ADDRESS[BLKADDR_W-1:INDEX_W];

  assign hit = valid_q[index] && (tag_q[index] == tag);

  icache_fsm u_fsm (
    .clk_i         (CLK),
    .rst_ni        (RESET),
    .hit_i         (hit),
    .blockAddr_i   (blockAddr),
    .memBusywait_i (MEM_BUSYWAIT),
    .memRead_o     (MEM_READ),
    .memAddress_o  (MEM_ADDRESS),
    .busywait_o    (BUSYWAIT),
    .capture_o     (capture),
    .lineWrite_o   (lineWrite)
  );

  // Valid bits and the fill register are the only storage needing reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q <= '0;
      fill_q  <= '0;
    end else begin
      if (capture) begin
        fill_q <= MEM_READDATA;
      end
      if (lineWrite) begin
        valid_q[wrIndex] <= 1'b1;
      end
    end
  end

  // Tag and data arrays are qualified by valid, so they need no reset.
  always_ff @(posedge CLK) begin
    if (lineWrite) begin
      tag_q[wrIndex]  <= wrTag;
      data_q[wrIndex] <= fill_q;
    end
  end

  always_comb begin
    INSTRUCTION = 32'h0;
    if (hit && !BUSYWAIT) begin
      INSTRUCTION = data_q[index][offset];
    end
  end

endmodule
